// File: rtl/cut_sched_pkg.sv
// -----------------------------------------------------------------------------
// cut_sched_pkg
// Shared definitions for the CUT access scheduler:
//   - default widths for the CUT primary-input / primary-output vectors and the
//     per-request apply-cycle count
//   - scheduler state encoding
//   - MISR feedback tap positions (used when CUT_SCHED_MISR_EN is defined)
//   - round-robin winner helper for the two-requester arbiter
// -----------------------------------------------------------------------------
package cut_sched_pkg;

  localparam int PI_W_DEF  = 35;
  localparam int PO_W_DEF  = 24;
  localparam int CNT_W_DEF = 8;

  // Feedback taps of the signature register: x^24 + x^23 + x^22 + x^17 style,
  // expressed as bit positions of the current signature.
  localparam int MISR_TAP_A = 23;
  localparam int MISR_TAP_B = 22;
  localparam int MISR_TAP_C = 21;
  localparam int MISR_TAP_D = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // Winning requester index for a non-zero request vector. When both request,
  // the one that was not served last wins.
  function automatic logic rr_winner(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

endpackage

// File: rtl/cut_sched_misr.sv
// -----------------------------------------------------------------------------
// cut_sched_misr
// Result signature register for the CUT access scheduler.
// Capture mode is selected at build time by macro CUT_SCHED_MISR_EN:
//   defined   : multiple-input signature register, each capture does
//               sig = {sig[PO_W-2:0], fb} ^ po, fb = xor of the tap bits
//   undefined : each capture loads sig = po (holds the last capture)
// Ports:
//   CK   in   clock
//   RN   in   synchronous active-low reset (clears the signature)
//   clr  in   clear the signature (new operation granted); wins over cap
//   cap  in   capture enable
//   po   in   PO_W  CUT primary outputs
//   sig  out  PO_W  current signature
// Requires PO_W > MISR_TAP_A when the MISR mode is enabled.
// -----------------------------------------------------------------------------
module cut_sched_misr
  import cut_sched_pkg::*;
#(
  parameter int PO_W = PO_W_DEF
) (
  input  logic            CK,
  input  logic            RN,
  input  logic            clr,
  input  logic            cap,
  input  logic [PO_W-1:0] po,
  output logic [PO_W-1:0] sig
);

  logic [PO_W-1:0] sig_q;
  logic [PO_W-1:0] sig_next;

`ifdef CUT_SCHED_MISR_EN
  logic fb;

  assign fb       = sig_q[MISR_TAP_A] ^ sig_q[MISR_TAP_B] ^
                    sig_q[MISR_TAP_C] ^ sig_q[MISR_TAP_D];
  assign sig_next = {sig_q[PO_W-2:0], fb} ^ po;
`else
  assign sig_next = po;
`endif

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples its inputs from the same pre-edge values.
  always_ff @(posedge CK) begin
    if (!RN) begin
      sig_q <= '0;
    end else if (clr) begin
      sig_q <= '0;
    end else if (cap) begin
      sig_q <= sig_next;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/cut_access_sched.sv
// -----------------------------------------------------------------------------
// cut_access_sched
// Two-requester scheduler giving exclusive access to a circuit under test.
// A granted request applies its stimulus vector for N cycles (N = NCYC, with 0
// treated as 1), collects N CUT responses (PO lags PI by one cycle) into a
// signature, and reports the result with a one-cycle strobe.
//   IDLE -> APPLY (N cycles) -> FLUSH (1) -> REPORT (1) -> IDLE
// Grants alternate round-robin when both requesters are active; after reset
// requester 0 wins first. ACK is a one-cycle pulse in the first APPLY cycle.
// Capture mode (MISR vs. last-value) is selected by macro CUT_SCHED_MISR_EN,
// see cut_sched_misr.
// Ports:
//   CK           in   clock, rising edge
//   RN           in   synchronous active-low reset
//   REQ          in   2      request level per requester
//   VEC0, VEC1   in   PI_W   stimulus vector of requester 0 / 1
//   NCYC0, NCYC1 in   CNT_W  apply-cycle count of requester 0 / 1
//   ACK          out  2      grant pulse to the winner
//   PI           out  PI_W   vector to the CUT (0 outside APPLY)
//   PI_VLD       out  1      high while PI is applied
//   PO           in   PO_W   CUT outputs, valid one cycle after PI
//   SIG          out  PO_W   result signature, held until the next grant
//   SIG_VLD      out  1      one-cycle result strobe
//   SIG_ID       out  1      requester the result belongs to
//   BUSY         out  1      high in every state except IDLE
// -----------------------------------------------------------------------------
module cut_access_sched
  import cut_sched_pkg::*;
#(
  parameter int PI_W  = PI_W_DEF,
  parameter int PO_W  = PO_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [1:0]       REQ,
  input  logic [PI_W-1:0]  VEC0,
  input  logic [PI_W-1:0]  VEC1,
  input  logic [CNT_W-1:0] NCYC0,
  input  logic [CNT_W-1:0] NCYC1,
  output logic [1:0]       ACK,
  output logic [PI_W-1:0]  PI,
  output logic             PI_VLD,
  input  logic [PO_W-1:0]  PO,
  output logic [PO_W-1:0]  SIG,
  output logic             SIG_VLD,
  output logic             SIG_ID,
  output logic             BUSY
);

  state_e           state_q, state_d;
  logic             last_q;
  logic [1:0]       ack_q;
  logic             sig_id_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] n_q;
  logic [PI_W-1:0]  vec_q;

  logic             grant;
  logic             win;
  logic             apply_done;
  logic             cap;
  logic [CNT_W-1:0] ncyc_sel;

  assign grant      = (state_q == ST_IDLE) && (REQ != 2'b00);
  assign win        = rr_winner(REQ, last_q);
  assign ncyc_sel   = win ? NCYC1 : NCYC0;
  // cnt_q counts APPLY cycles from 1 up to n_q (<= 2^CNT_W-1), so it never wraps.
  assign apply_done = (cnt_q == n_q);

  // --- state register ---
  always_ff @(posedge CK) begin
    if (!RN) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // --- next-state logic ---
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant)      state_d = ST_APPLY;
      ST_APPLY:  if (apply_done) state_d = ST_FLUSH;
      ST_FLUSH:                  state_d = ST_REPORT;
      ST_REPORT:                 state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // --- control registers ---
  always_ff @(posedge CK) begin
    if (!RN) begin
      last_q   <= 1'b1;
      ack_q    <= 2'b00;
      sig_id_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ack_q <= 2'b00;
      if (grant) begin
        ack_q    <= win ? 2'b10 : 2'b01;
        last_q   <= win;
        sig_id_q <= win;
        cnt_q    <= CNT_W'(1);
      end else if (state_q == ST_APPLY && !apply_done) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // --- operation data latched at grant ---
  // NOTE: these data registers have no reset; they are loaded on every grant
  // and only observed in APPLY, which is unreachable without a grant.
  always_ff @(posedge CK) begin
    if (grant) begin
      vec_q <= win ? VEC1 : VEC0;
      n_q   <= (ncyc_sel == '0) ? CNT_W'(1) : ncyc_sel;
    end
  end

  // PO of APPLY cycle k answers PI of cycle k-1: capture in APPLY cycles 2..N
  // and in FLUSH, which is N captures in total.
  assign cap = ((state_q == ST_APPLY) && (cnt_q != CNT_W'(1))) ||
               (state_q == ST_FLUSH);

  cut_sched_misr #(
    .PO_W (PO_W)
  ) u_misr (
    .CK  (CK),
    .RN  (RN),
    .clr (grant),
    .cap (cap),
    .po  (PO),
    .sig (SIG)
  );

  assign ACK     = ack_q;
  assign PI_VLD  = (state_q == ST_APPLY);
  assign PI      = (state_q == ST_APPLY) ? vec_q : '0;
  assign SIG_VLD = (state_q == ST_REPORT);
  assign SIG_ID  = sig_id_q;
  assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cut_access_sched.sv
// -----------------------------------------------------------------------------
// tb_cut_access_sched
// Self-checking bench for cut_access_sched. Each operation is predicted at the
// transaction level: round-robin winner, PI held for max(NCYC,1) cycles, a
// response captured in every cycle that follows a PI_VLD cycle, and a result
// strobe two cycles after the last PI_VLD cycle. Honors CUT_SCHED_MISR_EN.
// -----------------------------------------------------------------------------
module tb_cut_access_sched;

  localparam int PI_W  = 35;
  localparam int PO_W  = 24;
  localparam int CNT_W = 8;

  logic             CK = 1'b0;
  logic             RN;
  logic [1:0]       REQ;
  logic [PI_W-1:0]  VEC0, VEC1;
  logic [CNT_W-1:0] NCYC0, NCYC1;
  logic [1:0]       ACK;
  logic [PI_W-1:0]  PI;
  logic             PI_VLD;
  logic [PO_W-1:0]  PO;
  logic [PO_W-1:0]  SIG;
  logic             SIG_VLD;
  logic             SIG_ID;
  logic             BUSY;

  cut_access_sched #(
    .PI_W  (PI_W),
    .PO_W  (PO_W),
    .CNT_W (CNT_W)
  ) dut (
    .CK      (CK),
    .RN      (RN),
    .REQ     (REQ),
    .VEC0    (VEC0),
    .VEC1    (VEC1),
    .NCYC0   (NCYC0),
    .NCYC1   (NCYC1),
    .ACK     (ACK),
    .PI      (PI),
    .PI_VLD  (PI_VLD),
    .PO      (PO),
    .SIG     (SIG),
    .SIG_VLD (SIG_VLD),
    .SIG_ID  (SIG_ID),
    .BUSY    (BUSY)
  );

  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference state
  logic            model_last;
  logic [PO_W-1:0] model_sig;
  logic [PO_W-1:0] po_q[$];

  // Observations of the most recent operation
  int              ack_cyc;
  logic [1:0]      ack_obs;
  logic [PO_W-1:0] sig_obs;
  logic            sig_id_obs;
  int              vld_obs;

  task automatic step();
    @(posedge CK);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PO_W-1:0] sig_update(input logic [PO_W-1:0] s,
                                                 input logic [PO_W-1:0] p);
`ifdef CUT_SCHED_MISR_EN
    return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]} ^ p;
`else
    return p;
`endif
  endfunction

  function automatic logic [PI_W-1:0] rand_vec();
    return PI_W'({$urandom(), $urandom()});
  endfunction

  // Runs one operation. Call in an IDLE cycle (BUSY=0); returns in the IDLE
  // cycle after REPORT with REQ cleared.
  task automatic run_op(input logic [1:0] req, input logic [PI_W-1:0] v0,
                        input logic [PI_W-1:0] v1, input logic [CNT_W-1:0] n0,
                        input logic [CNT_W-1:0] n1);
    logic            w;
    int              n;
    logic [PI_W-1:0] v;
    logic [PO_W-1:0] pv;
    int              vld_cnt;
    int              last_vld_cyc;
    int              guard;
    bit              prev_vld;
    bit              done;

    REQ = req; VEC0 = v0; VEC1 = v1; NCYC0 = n0; NCYC1 = n1;
    w = (req == 2'b11) ? !model_last : req[1];
    n = w ? int'(n1) : int'(n0);
    if (n == 0) n = 1;
    v = w ? v1 : v0;
    model_last = w;
    model_sig  = '0;

    step();
    ack_obs = ACK;
    ack_cyc = cyc;
    check("ack", 64'(ACK), w ? 64'd2 : 64'd1);

    // Changes after the grant must not disturb the operation in flight.
    REQ   = 2'($urandom());
    VEC0  = rand_vec();
    VEC1  = rand_vec();
    NCYC0 = CNT_W'($urandom());
    NCYC1 = CNT_W'($urandom());

    prev_vld = 1'b0; done = 1'b0; guard = 0; vld_cnt = 0; last_vld_cyc = cyc;
    while (!done && guard < 400) begin
      if (PI_VLD === 1'b1) begin
        vld_cnt++;
        last_vld_cyc = cyc;
        if (vld_cnt == 1 || vld_cnt == n) check("pi_value", 64'(PI), 64'(v));
      end else if (prev_vld) begin
        check("pi_zero_after_apply", 64'(PI), 64'd0);
      end
      if (guard == 1) check("ack_pulse", 64'(ACK), 64'd0);
      if (SIG_VLD === 1'b1) begin
        done = 1'b1;
      end else begin
        if (prev_vld && po_q.size() > 0) pv = po_q.pop_front();
        else                             pv = PO_W'($urandom());
        PO = pv;
        if (prev_vld) model_sig = sig_update(model_sig, pv);
        prev_vld = (PI_VLD === 1'b1);
        step();
        guard++;
      end
    end

    check("sig_vld_seen", 64'(done), 64'd1);
    check("pi_vld_len", 64'(vld_cnt), 64'(n));
    check("sig_vld_delay", 64'(cyc - last_vld_cyc), 64'd2);
    check("sig", 64'(SIG), 64'(model_sig));
    check("sig_id", 64'(SIG_ID), 64'(w));
    check("busy_report", 64'(BUSY), 64'd1);
    sig_obs    = SIG;
    sig_id_obs = SIG_ID;
    vld_obs    = vld_cnt;

    step();
    REQ = 2'b00;
    check("idle_busy", 64'(BUSY), 64'd0);
    check("idle_sig_vld", 64'(SIG_VLD), 64'd0);
    check("sig_hold", 64'(SIG), 64'(model_sig));
  endtask

  initial begin
    int a0, a1, a2;
    int guard;
    logic [1:0] r;

    // ---- reset with both requesting ----
    RN = 1'b0; REQ = 2'b11; VEC0 = rand_vec(); VEC1 = rand_vec();
    NCYC0 = 8'd1; NCYC1 = 8'd1; PO = '0;
    step();
    step();
    check("rst_ack", 64'(ACK), 64'd0);
    check("rst_pi", 64'(PI), 64'd0);
    check("rst_pi_vld", 64'(PI_VLD), 64'd0);
    check("rst_sig", 64'(SIG), 64'd0);
    check("rst_sig_vld", 64'(SIG_VLD), 64'd0);
    check("rst_sig_id", 64'(SIG_ID), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    RN = 1'b1;
    model_last = 1'b1;

    // ---- REQ=11 held, N=1: 01, 10, 01 four cycles apart ----
    run_op(2'b11, rand_vec(), rand_vec(), 8'd1, 8'd1);
    a0 = ack_cyc;
    check("rr_ack0", 64'(ack_obs), 64'd1);
    run_op(2'b11, rand_vec(), rand_vec(), 8'd1, 8'd1);
    a1 = ack_cyc;
    check("rr_ack1", 64'(ack_obs), 64'd2);
    run_op(2'b11, rand_vec(), rand_vec(), 8'd1, 8'd1);
    a2 = ack_cyc;
    check("rr_ack2", 64'(ack_obs), 64'd1);
    check("rr_gap01", 64'(a1 - a0), 64'd4);
    check("rr_gap12", 64'(a2 - a1), 64'd4);

`ifdef CUT_SCHED_MISR_EN
    // ---- MISR: NCYC0=2, PO=1 on both captures -> 3 ----
    po_q = '{24'h000001, 24'h000001};
    run_op(2'b01, rand_vec(), rand_vec(), 8'd2, 8'd5);
    check("misr_sig", 64'(sig_obs), 64'h000003);
    check("misr_sig_id", 64'(sig_id_obs), 64'd0);
`else
    // ---- raw: NCYC1=3, captures A, B, C -> C ----
    po_q = '{24'h00000A, 24'h00000B, 24'h00000C};
    run_op(2'b10, rand_vec(), rand_vec(), 8'd5, 8'd3);
    check("raw_sig", 64'(sig_obs), 64'h00000C);
    check("raw_sig_id", 64'(sig_id_obs), 64'd1);
`endif
    po_q.delete();

    // ---- NCYC boundaries ----
    run_op(2'b01, rand_vec(), rand_vec(), 8'd0, 8'd7);
    check("ncyc0_len", 64'(vld_obs), 64'd1);
    run_op(2'b01, rand_vec(), rand_vec(), 8'd255, 8'd7);
    check("ncyc255_len", 64'(vld_obs), 64'd255);

    // ---- random operations ----
    for (int i = 0; i < 24; i++) begin
      r = 2'($urandom_range(1, 3));
      run_op(r, rand_vec(), rand_vec(), CNT_W'($urandom_range(0, 12)),
             CNT_W'($urandom_range(0, 12)));
    end

    // ---- reset in the middle of APPLY ----
    REQ = 2'b10; VEC1 = rand_vec(); NCYC1 = 8'd10;
    step();
    check("mid_ack", 64'(ACK), 64'd2);
    step();
    step();
    step();
    check("mid_apply_vld", 64'(PI_VLD), 64'd1);
    RN = 1'b0; REQ = 2'b11; NCYC0 = 8'd3; NCYC1 = 8'd3;
    step();
    check("mid_rst_ack", 64'(ACK), 64'd0);
    check("mid_rst_pi", 64'(PI), 64'd0);
    check("mid_rst_pi_vld", 64'(PI_VLD), 64'd0);
    check("mid_rst_sig", 64'(SIG), 64'd0);
    check("mid_rst_sig_vld", 64'(SIG_VLD), 64'd0);
    check("mid_rst_sig_id", 64'(SIG_ID), 64'd0);
    check("mid_rst_busy", 64'(BUSY), 64'd0);
    RN = 1'b1;
    step();
    check("post_rst_ack", 64'(ACK), 64'd1);
    REQ = 2'b00;
    guard = 0;
    while (BUSY !== 1'b0 && guard < 20) begin
      step();
      guard++;
    end
    check("post_rst_idle", 64'(BUSY), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cut_access_sched.md
CUT_ACCESS_SCHED -- requirements
Module: cut_access_sched

Interface
REQ-001 SHALL have parameter PI_W, default 35: width of the circuit-under-test (CUT) primary-input vector.
REQ-002 SHALL have parameter PO_W, default 24: width of the CUT primary-output vector.
REQ-003 SHALL have parameter CNT_W, default 8: width of the per-request apply-cycle count.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 CK  in  1  clock; all state updates on the rising edge.
REQ-006 RN  in  1  synchronous active-low reset.
REQ-007 REQ  in  2  per-requester request level.
REQ-008 VEC0, VEC1  in  PI_W  stimulus vector of requester 0 / 1.
REQ-009 NCYC0, NCYC1  in  CNT_W  apply-cycle count of requester 0 / 1.
REQ-010 ACK  out  2  one-cycle grant pulse to the winning requester.
REQ-011 PI  out  PI_W  vector driven to the CUT.
REQ-012 PI_VLD  out  1  high while PI is being applied.
REQ-013 PO  in  PO_W  CUT outputs; valid one cycle after the matching PI.
REQ-014 SIG  out  PO_W  result signature.
REQ-015 SIG_VLD  out  1  one-cycle result strobe.
REQ-016 SIG_ID  out  1  requester the result belongs to.
REQ-017 BUSY  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement four states: IDLE, APPLY, FLUSH, REPORT.
REQ-019 IDLE with REQ!=0: the winner SHALL be chosen round-robin against pointer LAST (requester !LAST wins when both request); the block SHALL pulse ACK[w], latch VECw and NCYCw, clear SIG, set LAST=w and go to APPLY.
REQ-020 A latched NCYC of 0 SHALL be treated as 1.
REQ-021 APPLY SHALL drive PI=latched vector with PI_VLD=1 for exactly N cycles, then go to FLUSH.
REQ-022 PO SHALL be captured in APPLY cycles 2..N and in the FLUSH cycle, giving exactly N captures; FLUSH lasts one cycle, has PI_VLD=0, then goes to REPORT.
REQ-023 REPORT SHALL assert SIG_VLD for one cycle with SIG_ID=LAST and SIG stable, then return to IDLE.
REQ-024 SIG SHALL hold its value until the next grant.
REQ-025 Outside APPLY, PI SHALL be 0 and PI_VLD SHALL be 0.
REQ-026 REQ changes after ACK SHALL not affect the operation in flight.
REQ-027 A REQ still high after its result SHALL compete again in the next IDLE cycle.
REQ-028 Grant-to-grant spacing SHALL be N+3 cycles minimum.
REQ-029 NCYC=255 SHALL complete without counter wrap.

Reset
REQ-030 RN=0 at any clock edge, including mid-APPLY, SHALL force state=IDLE, LAST=1 (requester 0 wins first), and ACK, PI, PI_VLD, SIG, SIG_VLD, SIG_ID, BUSY all 0.
REQ-031 The first REQ SHALL be arbitrated in the cycle after RN rises.

Configuration
REQ-032 Macro CUT_SCHED_MISR_EN SHALL select the capture mode.
REQ-033 With CUT_SCHED_MISR_EN defined, each capture SHALL update SIG = {SIG[PO_W-2:0], SIG[23]^SIG[22]^SIG[21]^SIG[16]} ^ PO.
REQ-034 Without CUT_SCHED_MISR_EN, each capture SHALL set SIG = PO, so SIG holds the last capture.
REQ-035 Nothing else SHALL differ between the two modes.

Structure
REQ-036 Package cut_sched_pkg SHALL hold the state enum, PI_W/PO_W/CNT_W defaults and the MISR tap constants.
REQ-037 The signature register SHALL be sub-module cut_sched_misr (clear, capture enable, PO in, SIG out), containing the macro-dependent logic.

Verification
REQ-038 Reset mid-APPLY -> next cycle all outputs 0 and BUSY=0; subsequent REQ=2'b11 -> ACK=2'b01.
REQ-039 REQ=2'b11 held, NCYC0=NCYC1=1 -> ACK sequence 01, 10, 01, with grants 4 cycles apart.
REQ-040 MISR mode, NCYC0=2, PO=24'h000001 constant -> SIG=24'h000003, SIG_ID=0.
REQ-041 Raw mode, NCYC1=3, PO=24'hA, 24'hB, 24'hC on successive captures -> SIG=24'h00000C, SIG_ID=1.
REQ-042 NCYC0=0 -> PI_VLD high exactly 1 cycle; NCYC0=255 -> PI_VLD high exactly 255 cycles and SIG_VLD 2 cycles after PI_VLD falls.
